// File: rtl/instr_prefetch_queue.sv
// Instruction prefetch queue: single-outstanding fetch engine feeding a 4-entry {instr, pc+4} FIFO.
// Optional PREFETCH_BYPASS_EN forwards an ack straight to the outputs when the queue is empty.
module instr_prefetch_queue (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc4,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err,
  output logic        fetch_err
);

  // state    | meaning
  // ST_IDLE  | no request outstanding
  // ST_REQ   | request outstanding, returned data will be queued
  // ST_DRAIN | request outstanding, returned data will be dropped
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [31:0] NOP_INSTR = 32'hFC00_0000;
  localparam logic [2:0]  DEPTH     = 3'd4;

  logic [1:0]  state, state_nxt;
  logic [31:0] fpc;
  logic [31:0] req_addr;
  logic [2:0]  count;
  logic [1:0]  rd_ptr, wr_ptr;
  logic [31:0] instr_q [4];
  logic [31:0] pc4_q   [4];

  logic        ack_take;
  logic        issue;
  logic        push;
  logic        pop;
  logic        head_valid;
  logic [31:0] push_instr;
  logic [31:0] push_pc4;

  assign ack_take   = (state == ST_REQ) && mem_ack && !redirect_valid;
  assign issue      = (state == ST_IDLE) && (count < DEPTH) && !redirect_valid;
  assign head_valid = (count != 3'd0);
  assign pop        = head_valid && !stall && !redirect_valid;
  assign push_instr = mem_err ? NOP_INSTR : mem_rdata;
  assign push_pc4   = fpc + 32'd4;

  // req_addr is captured at issue so the bus address survives a redirect while draining
  assign mem_req  = (state != ST_IDLE);
  assign mem_addr = req_addr;

`ifdef PREFETCH_BYPASS_EN
  logic bypass_hit;
  assign bypass_hit = ack_take && !head_valid;
  // a bypassed word consumed this cycle never enters the queue
  assign push      = ack_take && !(bypass_hit && !stall);
  assign out_valid = head_valid || bypass_hit;
  assign out_instr = head_valid ? instr_q[rd_ptr] : (bypass_hit ? push_instr : NOP_INSTR);
  assign out_pc4   = head_valid ? pc4_q[rd_ptr]   : (bypass_hit ? push_pc4   : 32'd0);
`else
  assign push      = ack_take;
  assign out_valid = head_valid;
  assign out_instr = head_valid ? instr_q[rd_ptr] : NOP_INSTR;
  assign out_pc4   = head_valid ? pc4_q[rd_ptr]   : 32'd0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (issue) state_nxt = ST_REQ;
      ST_REQ: begin
        if (mem_ack)             state_nxt = ST_IDLE;
        else if (redirect_valid) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: if (mem_ack) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state     <= ST_IDLE;
      fpc       <= 32'd0;
      req_addr  <= 32'd0;
      count     <= 3'd0;
      rd_ptr    <= 2'd0;
      wr_ptr    <= 2'd0;
      fetch_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (issue) req_addr <= fpc;
      if (redirect_valid) begin
        fpc    <= redirect_pc & 32'hFFFF_FFFC;
        count  <= 3'd0;
        rd_ptr <= 2'd0;
        wr_ptr <= 2'd0;
      end else begin
        if (ack_take) fpc <= push_pc4;
        if (push) wr_ptr <= wr_ptr + 2'd1;
        if (pop)  rd_ptr <= rd_ptr + 2'd1;
        case ({push, pop})
          2'b10:   count <= count + 3'd1;
          2'b01:   count <= count - 3'd1;
          default: count <= count;
        endcase
      end
      if (ack_take && mem_err) fetch_err <= 1'b1;
    end
  end

  always_ff @(posedge Clk) begin
    if (push) begin
      instr_q[wr_ptr] <= push_instr;
      pc4_q[wr_ptr]   <= push_pc4;
    end
  end

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// Self-checking bench for instr_prefetch_queue: vector table, directed corner sequences,
// and a randomized run against a queue-based reference model.
module tb_instr_prefetch_queue;

  localparam logic [31:0] NOP = 32'hFC00_0000;
  localparam logic [31:0] KEY = 32'h5A5A_0000;

  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'd0;
  logic        stall = 1'b0;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc4;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_err = 1'b0;
  logic        fetch_err;

  int checks = 0;
  int failures = 0;

  instr_prefetch_queue dut (
    .Clk(Clk), .Rst(Rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .out_valid(out_valid), .out_instr(out_instr), .out_pc4(out_pc4),
    .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .fetch_err(fetch_err)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    redirect_valid = 1'b0; redirect_pc = 32'd0; stall = 1'b0;
    mem_ack = 1'b0; mem_rdata = 32'd0; mem_err = 1'b0;
    repeat (2) @(negedge Clk);
    Rst = 1'b0;
    #1;
    chk("rst_mem_req",   {31'd0, mem_req},   32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr,          NOP);
    chk("rst_out_pc4",   out_pc4,            32'd0);
    chk("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
  endtask

  // one cycle: inputs at negedge, ack only while a request is up, data derived from address
  task automatic cyc(input logic r, input logic [31:0] rpc, input logic st,
                     input logic ack, input logic er);
    @(negedge Clk);
    redirect_valid = r;
    redirect_pc    = rpc;
    stall          = st;
    mem_ack        = ack & mem_req;
    mem_rdata      = mem_addr ^ KEY;
    mem_err        = er;
    #1;
  endtask

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc4;
  } vec_t;

  vec_t tbl [8];

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc4;
  } ent_t;

  ent_t        mq [$];
  logic [31:0] m_fpc;
  logic [31:0] m_addr;
  logic        m_out;
  logic        m_want;
  logic        m_ferr;

  task automatic model_step(input logic r, input logic [31:0] rpc, input logic st,
                            input logic ack, input logic [31:0] rd, input logic er);
    int   old;
    logic do_pop;
    logic do_push;
    ent_t e;
    e = '{instr: 32'd0, pc4: 32'd0};
    if (r) begin
      mq.delete();
      m_fpc = rpc & 32'hFFFF_FFFC;
      if (m_out && ack) m_out = 1'b0;
      else if (m_out)   m_want = 1'b0;
    end else begin
      old     = mq.size();
      do_pop  = (old > 0) && !st;
      do_push = 1'b0;
      if (m_out && ack) begin
        if (m_want) begin
          do_push = 1'b1;
          e.instr = er ? NOP : rd;
          e.pc4   = m_fpc + 32'd4;
          m_fpc   = m_fpc + 32'd4;
          if (er) m_ferr = 1'b1;
        end
        m_out = 1'b0;
      end else if (!m_out && old < 4) begin
        m_out  = 1'b1;
        m_want = 1'b1;
        m_addr = m_fpc;
      end
`ifdef PREFETCH_BYPASS_EN
      if (do_push && old == 0 && !st) do_push = 1'b0;
`endif
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back(e);
    end
  endtask

  initial begin
    logic        e_valid;
    logic [31:0] e_instr;
    logic [31:0] e_pc4;
    int          stall_pct;

    tbl[0] = '{1'b1, 32'h1111_0000, 1'b1, 32'd0,  1'b0, NOP,          32'd0};
    tbl[1] = '{1'b0, 32'h0,         1'b0, 32'd0,  1'b1, 32'h1111_0000, 32'd4};
    tbl[2] = '{1'b1, 32'h1111_0001, 1'b1, 32'd4,  1'b0, NOP,          32'd0};
    tbl[3] = '{1'b0, 32'h0,         1'b0, 32'd0,  1'b1, 32'h1111_0001, 32'd8};
    tbl[4] = '{1'b1, 32'h1111_0002, 1'b1, 32'd8,  1'b0, NOP,          32'd0};
    tbl[5] = '{1'b0, 32'h0,         1'b0, 32'd0,  1'b1, 32'h1111_0002, 32'd12};
    tbl[6] = '{1'b1, 32'h1111_0003, 1'b1, 32'd12, 1'b0, NOP,          32'd0};
    tbl[7] = '{1'b0, 32'h0,         1'b0, 32'd0,  1'b1, 32'h1111_0003, 32'd16};

    // streaming fetch from reset, 1-cycle acks
    do_reset();
    foreach (tbl[i]) begin
      @(negedge Clk);
      redirect_valid = 1'b0; stall = 1'b0; mem_err = 1'b0;
      mem_ack = tbl[i].ack; mem_rdata = tbl[i].rdata;
      #1;
      chk("tbl_mem_req", {31'd0, mem_req}, {31'd0, tbl[i].exp_req});
      if (tbl[i].exp_req) chk("tbl_mem_addr", mem_addr, tbl[i].exp_addr);
      chk("tbl_out_valid", {31'd0, out_valid}, {31'd0, tbl[i].exp_valid});
      chk("tbl_out_instr", out_instr, tbl[i].exp_instr);
      chk("tbl_out_pc4",   out_pc4,   tbl[i].exp_pc4);
    end

    // continuous stall fills the queue, then release drains it
    do_reset();
    repeat (10) cyc(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
    chk("full_mem_req", {31'd0, mem_req}, 32'd0);
    chk("full_head_pc4", out_pc4, 32'd4);
    chk("full_head_instr", out_instr, 32'd0 ^ KEY);
    cyc(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
    chk("full_hold_req", {31'd0, mem_req}, 32'd0);
    chk("full_hold_pc4", out_pc4, 32'd4);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
      chk("drain_pc4", out_pc4, 32'd4 * (k + 1));
      chk("drain_instr", out_instr, (32'd4 * k) ^ KEY);
    end
    cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("drain_empty", {31'd0, out_valid}, 32'd0);
    chk("resume_req", {31'd0, mem_req}, 32'd1);
    chk("resume_addr", mem_addr, 32'd16);

    // redirect (under stall) while fetching 0x8
    do_reset();
    repeat (4) cyc(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("pre_redir_addr", mem_addr, 32'd8);
    chk("pre_redir_valid", {31'd0, out_valid}, 32'd1);
    cyc(1'b1, 32'h0000_0103, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("redir_flush", {31'd0, out_valid}, 32'd0);
    chk("drain_req", {31'd0, mem_req}, 32'd1);
    chk("drain_addr", mem_addr, 32'd8);
    cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("drain_addr_hold", mem_addr, 32'd8);
    cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
    cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("drain_discard", {31'd0, out_valid}, 32'd0);
    chk("drain_err_ign", {31'd0, fetch_err}, 32'd0);
    chk("drain_idle", {31'd0, mem_req}, 32'd0);
    cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    chk("redir_addr", mem_addr, 32'h0000_0100);
    cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("redir_pc4", out_pc4, 32'h0000_0104);
    chk("redir_instr", out_instr, 32'h0000_0100 ^ KEY);

    // fetch fault at 0x4 is sticky until reset
    do_reset();
    cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("err_pre_flag", {31'd0, fetch_err}, 32'd0);
    cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b1);
    chk("err_addr", mem_addr, 32'd4);
    cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("err_instr", out_instr, NOP);
    chk("err_pc4", out_pc4, 32'd8);
    chk("err_flag", {31'd0, fetch_err}, 32'd1);
    repeat (6) cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    chk("err_sticky", {31'd0, fetch_err}, 32'd1);

    // wrap at top of address space; redirect coinciding with ack discards it
    do_reset();
    cyc(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("wrap_nodata", {31'd0, out_valid}, 32'd0);
    cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    chk("wrap_addr0", mem_addr, 32'hFFFF_FFFC);
    cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("wrap_valid", {31'd0, out_valid}, 32'd1);
    chk("wrap_pc4", out_pc4, 32'd0);
    cyc(1'b0, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("wrap_addr1", mem_addr, 32'd0);
    chk("wrap_req1", {31'd0, mem_req}, 32'd1);

    // reset during outstanding request at 0x10, late ack after release
    do_reset();
    repeat (7) cyc(1'b0, 32'd0, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 32'd0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    chk("mid_addr", mem_addr, 32'h10);
    chk("mid_valid", {31'd0, out_valid}, 32'd1);
    #1 Rst = 1'b1;
    #1;
    chk("async_req", {31'd0, mem_req}, 32'd0);
    chk("async_valid", {31'd0, out_valid}, 32'd0);
    chk("async_instr", out_instr, NOP);
    @(negedge Clk);
    stall = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    Rst = 1'b0;
    @(negedge Clk);
    mem_ack = 1'b0;
    #1;
    chk("late_ack_valid", {31'd0, out_valid}, 32'd0);
    chk("post_rst_req", {31'd0, mem_req}, 32'd1);
    chk("post_rst_addr", mem_addr, 32'd0);

    // randomized run against reference model
    do_reset();
    mq.delete();
    m_fpc = 32'd0; m_addr = 32'd0; m_out = 1'b0; m_want = 1'b0; m_ferr = 1'b0;
    stall_pct = 0;
    for (int n = 0; n < 4000; n++) begin
      if (n % 250 == 0) stall_pct = (n / 250) % 3 == 0 ? 10 : ((n / 250) % 3 == 1 ? 50 : 92);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15))
                                                   : $urandom;
      stall          = ($urandom_range(0, 99) < stall_pct);
      mem_ack        = m_out && ($urandom_range(0, 2) != 0);
      mem_rdata      = $urandom;
      mem_err        = ($urandom_range(0, 15) == 0);
      #1;
      e_valid = (mq.size() > 0);
      e_instr = e_valid ? mq[0].instr : NOP;
      e_pc4   = e_valid ? mq[0].pc4   : 32'd0;
`ifdef PREFETCH_BYPASS_EN
      if (!e_valid && m_out && m_want && mem_ack && !redirect_valid) begin
        e_valid = 1'b1;
        e_instr = mem_err ? NOP : mem_rdata;
        e_pc4   = m_fpc + 32'd4;
      end
`endif
      chk("rnd_mem_req", {31'd0, mem_req}, {31'd0, m_out});
      if (m_out) chk("rnd_mem_addr", mem_addr, m_addr);
      chk("rnd_out_valid", {31'd0, out_valid}, {31'd0, e_valid});
      chk("rnd_out_instr", out_instr, e_instr);
      chk("rnd_out_pc4", out_pc4, e_pc4);
      chk("rnd_fetch_err", {31'd0, fetch_err}, {31'd0, m_ferr});
      @(posedge Clk);
      model_step(redirect_valid, redirect_pc, stall, mem_ack, mem_rdata, mem_err);
      @(negedge Clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
